// File: rtl/stage_execute.sv
// Execute stage: ALU, jump redirect, data-memory handshake and register-file
// forward/writeback ports; holds decode while a memory access is outstanding.
module stage_execute #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [31:0] in_m,
    input  logic [3:0]  in_dest,
    input  logic [3:0]  in_aluop,
    input  logic        in_mem,
    input  logic        in_mem_write,
    input  logic        in_jump,
    output logic        stall_out,
    output logic        forward_valid,
    output logic [3:0]  forward_addr,
    output logic [31:0] forward_data,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc
);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] alu_result;
    logic [31:0] link_pc;
    logic        is_load;
    logic        is_store;
    logic        wb_valid;

    // A jump overrides any memory flag that happens to be set alongside it.
    assign is_load      = in_mem & ~in_mem_write & ~in_jump;
    assign is_store     = in_mem &  in_mem_write & ~in_jump;
    assign link_pc      = in_pc + 32'd4;
    assign forward_addr = in_dest;
    assign mem_addr     = alu_result;
    assign mem_wdata    = in_m;

    always_comb begin
        alu_result = 32'd0;
        case (in_aluop)
            4'h0:    alu_result = in_a + in_b;
            4'h1:    alu_result = in_a - in_b;
            4'h2:    alu_result = in_a & in_b;
            4'h3:    alu_result = in_a | in_b;
            4'h4:    alu_result = in_a ^ in_b;
            4'h5:    alu_result = in_a << in_b[4:0];
            4'h6:    alu_result = in_a >> in_b[4:0];
            4'h7:    alu_result = $signed(in_a) >>> in_b[4:0];
            4'h8:    alu_result = {31'd0, $signed(in_a) < $signed(in_b)};
            4'h9:    alu_result = {31'd0, in_a < in_b};
            4'hA:    alu_result = in_b;
            default: alu_result = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A load leaves IDLE once its request is accepted; mem_rvalid seen in IDLE is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (is_load && mem_ready) state_next = WAIT;
            WAIT:    if (mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall_out     = 1'b0;
        forward_valid = 1'b1;
        forward_data  = in_jump ? link_pc : alu_result;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        wb_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    mem_req   = 1'b1;
                    mem_we    = 1'b1;
                    stall_out = ~mem_ready;
                end else if (is_load) begin
                    mem_req       = 1'b1;
                    stall_out     = 1'b1;
                    forward_valid = 1'b0;
                end else begin
                    wb_valid = 1'b1;
                end
            end
            WAIT: begin
                stall_out     = ~mem_rvalid;
                forward_valid = mem_rvalid;
                forward_data  = mem_rdata;
                wb_valid      = mem_rvalid;
            end
            default: begin
                stall_out = 1'b0;
            end
        endcase
    end

    // wb_addr drops to 0 on every cycle that does not complete a register write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_addr        <= 4'd0;
            wb_data        <= 32'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= RESET_PC;
        end else begin
            redirect_valid <= 1'b0;
            wb_addr        <= wb_valid ? in_dest : 4'd0;
            if (wb_valid) begin
                wb_data <= forward_data;
            end
            if (state == IDLE && in_jump) begin
                redirect_valid <= 1'b1;
                redirect_pc    <= alu_result;
            end
        end
    end

endmodule

// File: tb/tb_stage_execute.sv
// Bench for stage_execute: directed cases followed by random instructions checked
// by a scoreboard against a behavioural model with a randomly timed memory responder.
module tb_stage_execute;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_pc, in_a, in_b, in_m;
    logic [3:0]  in_dest, in_aluop;
    logic        in_mem, in_mem_write, in_jump;
    logic        stall_out, forward_valid;
    logic [3:0]  forward_addr, wb_addr;
    logic [31:0] forward_data, wb_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, mem_rvalid;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        man_ready, man_rvalid;
    logic [31:0] man_rdata;
    logic        auto_ready, auto_rvalid;
    logic [31:0] auto_rdata;
    logic        auto_mem;
    logic        monitor_en;

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_wb_addr[$];
    logic [31:0] exp_wb_data[$];
    logic [31:0] exp_redir[$];
    logic [31:0] exp_mem_addr[$];
    logic        exp_mem_we[$];
    logic [31:0] exp_mem_wdata[$];

    logic [31:0] ram[bit [31:0]];
    logic [31:0] ref_mem[bit [31:0]];

    assign mem_ready  = auto_mem ? auto_ready  : man_ready;
    assign mem_rvalid = auto_mem ? auto_rvalid : man_rvalid;
    assign mem_rdata  = auto_mem ? auto_rdata  : man_rdata;

    stage_execute dut (
        .clk           (clk),
        .rst           (rst),
        .in_pc         (in_pc),
        .in_a          (in_a),
        .in_b          (in_b),
        .in_m          (in_m),
        .in_dest       (in_dest),
        .in_aluop      (in_aluop),
        .in_mem        (in_mem),
        .in_mem_write  (in_mem_write),
        .in_jump       (in_jump),
        .stall_out     (stall_out),
        .forward_valid (forward_valid),
        .forward_addr  (forward_addr),
        .forward_data  (forward_data),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic report_missing(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=present expected=none", name);
    endtask

    task automatic apply_stimulus(input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] m, input logic [3:0] dest, input logic [3:0] op,
                                  input logic mem, input logic we, input logic jump);
        in_pc = pc; in_a = a; in_b = b; in_m = m; in_dest = dest; in_aluop = op;
        in_mem = mem; in_mem_write = we; in_jump = jump;
    endtask

    task automatic apply_bubble();
        apply_stimulus(32'd0, 32'd0, 32'd0, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Behavioural ALU written from the operation table, not from the RTL.
    function automatic logic [31:0] model_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        int unsigned sh;
        sa = a;
        sb = b;
        sh = b % 32;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return a ^ b;
            4'h5: return a << sh;
            4'h6: return a >> sh;
            4'h7: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'h8: return (sa < sb) ? 32'd1 : 32'd0;
            4'h9: return (a < b) ? 32'd1 : 32'd0;
            4'hA: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] mem_init(input logic [31:0] addr);
        return {addr[15:0], 16'hBEEF} ^ 32'h1357_0000;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] addr);
        if (ref_mem.exists(addr)) return ref_mem[addr];
        return mem_init(addr);
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    // Memory responder: random accept delay, then read data 1-3 cycles after accept.
    initial begin
        bit          pend;
        bit          counting;
        int          rdly;
        int          vdly;
        logic [31:0] paddr;
        pend = 0; counting = 0; rdly = 0; vdly = 0; paddr = 0;
        auto_ready = 0; auto_rvalid = 0; auto_rdata = 0;
        forever begin
            @(posedge clk);
            #2;
            auto_ready  = 1'b0;
            auto_rvalid = 1'b0;
            auto_rdata  = $urandom;
            if (rst || !auto_mem) begin
                pend = 0;
                counting = 0;
            end else if (pend) begin
                if (vdly == 0) begin
                    auto_rvalid = 1'b1;
                    auto_rdata  = ram.exists(paddr) ? ram[paddr] : mem_init(paddr);
                    pend = 0;
                end else begin
                    vdly--;
                end
            end else if (mem_req) begin
                if (!counting) begin
                    counting = 1;
                    rdly = $urandom_range(0, 2);
                end
                if (rdly == 0) begin
                    auto_ready = 1'b1;
                    counting = 0;
                    if (mem_we) begin
                        ram[mem_addr] = mem_wdata;
                    end else begin
                        pend = 1;
                        paddr = mem_addr;
                        vdly = $urandom_range(0, 2);
                    end
                end else begin
                    rdly--;
                end
            end
        end
    end

    // Scoreboard monitor: pops expectations whenever the DUT presents a result.
    always @(negedge clk) begin
        if (monitor_en && !rst) begin
            if (wb_addr != 4'd0) begin
                if (exp_wb_addr.size() == 0) begin
                    report_missing("unexpected_wb");
                end else begin
                    check_output("wb_addr", wb_addr, exp_wb_addr.pop_front());
                    check_output("wb_data", wb_data, exp_wb_data.pop_front());
                end
            end
            if (forward_valid && forward_addr != 4'd0) begin
                if (exp_wb_addr.size() == 0) begin
                    report_missing("unexpected_forward");
                end else begin
                    check_output("fwd_addr", forward_addr, exp_wb_addr[0]);
                    check_output("fwd_data", forward_data, exp_wb_data[0]);
                end
            end
            if (redirect_valid) begin
                if (exp_redir.size() == 0) begin
                    report_missing("unexpected_redirect");
                end else begin
                    check_output("redirect_pc", redirect_pc, exp_redir.pop_front());
                end
            end
            if (mem_req && mem_ready) begin
                if (exp_mem_addr.size() == 0) begin
                    report_missing("unexpected_mem_req");
                end else begin
                    logic        we_e;
                    logic [31:0] wd_e;
                    we_e = exp_mem_we.pop_front();
                    wd_e = exp_mem_wdata.pop_front();
                    check_output("mem_addr", mem_addr, exp_mem_addr.pop_front());
                    check_output("mem_we", mem_we, we_e);
                    if (we_e) check_output("mem_wdata", mem_wdata, wd_e);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    int          stall_cycles;
    int          waited;
    int          kind;
    logic [31:0] r_pc, r_a, r_b, r_m, res;
    logic [3:0]  r_dest, r_op;
    logic        r_mem, r_we, r_jump;

    initial begin
        rst = 1'b1; auto_mem = 1'b0; monitor_en = 1'b0;
        man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = 32'd0;
        apply_bubble();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("reset_wb_addr", wb_addr, 32'd0);
        check_output("reset_wb_data", wb_data, 32'd0);
        check_output("reset_redirect_valid", redirect_valid, 32'd0);
        check_output("reset_redirect_pc", redirect_pc, 32'd0);
        check_output("reset_stall", stall_out, 32'd0);

        // ADD then writeback one cycle later
        @(posedge clk); #1;
        rst = 1'b0;
        apply_stimulus(32'd0, 32'd5, 32'd7, 32'd0, 4'd3, 4'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("add_fwd_valid", forward_valid, 32'd1);
        check_output("add_fwd_addr", forward_addr, 32'd3);
        check_output("add_fwd_data", forward_data, 32'd12);
        check_output("add_stall", stall_out, 32'd0);
        @(posedge clk); #1;
        apply_stimulus(32'd0, 32'd0, 32'd1, 32'd0, 4'd1, 4'h1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("add_wb_addr", wb_addr, 32'd3);
        check_output("add_wb_data", wb_data, 32'd12);
        check_output("sub_fwd_data", forward_data, 32'hFFFF_FFFF);
        @(posedge clk); #1;
        apply_stimulus(32'd0, 32'h8000_0000, 32'd4, 32'd0, 4'd2, 4'h7, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("sar_fwd_data", forward_data, 32'hF800_0000);
        @(posedge clk); #1;
        apply_stimulus(32'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 4'd2, 4'h9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_output("sltu_fwd_data", forward_data, 32'd1);

        // Load: accepted two cycles late, data three cycles after that
        stall_cycles = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            @(posedge clk); #1;
            if (cyc == 0) apply_stimulus(32'd0, 32'h40, 32'd0, 32'd0, 4'd5, 4'h0, 1'b1, 1'b0, 1'b0);
            man_ready  = (cyc == 2);
            man_rvalid = (cyc == 5);
            man_rdata  = (cyc == 5) ? 32'hDEAD_BEEF : 32'd0;
            @(negedge clk);
            if (stall_out) stall_cycles++;
            check_output("load_fwd_valid", forward_valid, {31'd0, cyc == 5});
            if (cyc == 1) begin
                check_output("load_mem_req", mem_req, 32'd1);
                check_output("load_mem_addr", mem_addr, 32'h40);
                check_output("load_mem_we", mem_we, 32'd0);
            end
            if (cyc == 5) check_output("load_fwd_data", forward_data, 32'hDEAD_BEEF);
        end
        check_output("load_stall_cycles", stall_cycles, 32'd5);
        @(posedge clk); #1;
        apply_bubble();
        man_rvalid = 1'b0;
        @(negedge clk);
        check_output("load_wb_addr", wb_addr, 32'd5);
        check_output("load_wb_data", wb_data, 32'hDEAD_BEEF);

        // Store accepted immediately
        @(posedge clk); #1;
        apply_stimulus(32'd0, 32'h80, 32'd4, 32'h1234, 4'd0, 4'h0, 1'b1, 1'b1, 1'b0);
        man_ready = 1'b1;
        @(negedge clk);
        check_output("store_mem_req", mem_req, 32'd1);
        check_output("store_mem_we", mem_we, 32'd1);
        check_output("store_mem_addr", mem_addr, 32'h84);
        check_output("store_mem_wdata", mem_wdata, 32'h1234);
        check_output("store_stall", stall_out, 32'd0);
        @(posedge clk); #1;
        apply_bubble();
        man_ready = 1'b0;
        @(negedge clk);
        check_output("store_wb_addr", wb_addr, 32'd0);

        // Jump with link
        @(posedge clk); #1;
        apply_stimulus(32'h100, 32'h200, 32'h10, 32'd0, 4'd14, 4'h0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        check_output("jump_fwd_data", forward_data, 32'h104);
        @(posedge clk); #1;
        apply_bubble();
        @(negedge clk);
        check_output("jump_redirect_valid", redirect_valid, 32'd1);
        check_output("jump_redirect_pc", redirect_pc, 32'h210);
        check_output("jump_wb_addr", wb_addr, 32'd14);
        check_output("jump_wb_data", wb_data, 32'h104);
        @(posedge clk); #1;
        @(negedge clk);
        check_output("jump_redirect_pulse", redirect_valid, 32'd0);

        // Reset while waiting for load data; the late data must be ignored
        @(posedge clk); #1;
        apply_stimulus(32'd0, 32'h40, 32'd0, 32'd0, 4'd6, 4'h0, 1'b1, 1'b0, 1'b0);
        man_ready = 1'b1;
        @(posedge clk); #1;
        man_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_output("wait_stall", stall_out, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        apply_bubble();
        man_rvalid = 1'b1;
        man_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        check_output("rst_wait_stall", stall_out, 32'd0);
        check_output("rst_wait_fwd_data", forward_data, 32'd0);
        @(posedge clk); #1;
        man_rvalid = 1'b0;
        @(negedge clk);
        check_output("rst_wait_wb_addr", wb_addr, 32'd0);
        check_output("rst_wait_stall_after", stall_out, 32'd0);

        // Random instruction stream
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        auto_mem = 1'b1;
        monitor_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            kind   = $urandom_range(0, 9);
            r_pc   = $urandom & 32'hFFFF_FFFC;
            r_a    = pick_operand();
            r_b    = pick_operand();
            r_m    = $urandom;
            r_dest = 4'($urandom_range(0, 15));
            r_op   = 4'($urandom_range(0, 15));
            r_mem  = 1'b0;
            r_we   = 1'($urandom_range(0, 1));
            r_jump = 1'b0;
            if (kind == 9) begin
                r_dest = 4'd0;
            end else if (kind == 6 || kind == 7) begin
                r_op  = 4'h0;
                r_a   = 32'($urandom_range(0, 15)) * 32'd4;
                r_b   = 32'($urandom_range(0, 3)) * 32'd4;
                r_mem = 1'b1;
                r_we  = (kind == 7);
                if (kind == 7) r_dest = 4'd0;
            end else if (kind == 8) begin
                r_jump = 1'b1;
                r_mem  = 1'($urandom_range(0, 1));
            end
            res = model_alu(r_op, r_a, r_b);
            if (r_jump) begin
                exp_redir.push_back(res);
                if (r_dest != 4'd0) begin
                    exp_wb_addr.push_back(r_dest);
                    exp_wb_data.push_back(r_pc + 32'd4);
                end
            end else if (r_mem && r_we) begin
                exp_mem_addr.push_back(res);
                exp_mem_we.push_back(1'b1);
                exp_mem_wdata.push_back(r_m);
                ref_mem[res] = r_m;
            end else if (r_mem) begin
                exp_mem_addr.push_back(res);
                exp_mem_we.push_back(1'b0);
                exp_mem_wdata.push_back(32'd0);
                if (r_dest != 4'd0) begin
                    exp_wb_addr.push_back(r_dest);
                    exp_wb_data.push_back(ref_read(res));
                end
            end else if (r_dest != 4'd0) begin
                exp_wb_addr.push_back(r_dest);
                exp_wb_data.push_back(res);
            end
            apply_stimulus(r_pc, r_a, r_b, r_m, r_dest, r_op, r_mem, r_we, r_jump);
            waited = 0;
            @(negedge clk);
            while (stall_out && waited < 40) begin
                waited++;
                @(negedge clk);
            end
            if (stall_out) begin
                report_missing("stall_timeout");
                break;
            end
            @(posedge clk); #1;
        end
        apply_bubble();
        repeat (3) @(negedge clk);
        monitor_en = 1'b0;
        check_output("wb_queue_drained", exp_wb_addr.size(), 32'd0);
        check_output("redirect_queue_drained", exp_redir.size(), 32'd0);
        check_output("mem_queue_drained", exp_mem_addr.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
